// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit path: scheduler FSM states,
// data-bit-number encodings and the byte width.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    SEND   = 2'd2
  } state_t;

  // cfg_data_bit_num encodings: number of data bits per frame.
  localparam logic [1:0] DBITS_5 = 2'b00;
  localparam logic [1:0] DBITS_6 = 2'b01;
  localparam logic [1:0] DBITS_7 = 2'b10;
  localparam logic [1:0] DBITS_8 = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests by ptr, pick the lowest
// set bit, rotate the index back. Reports one-hot grant, binary index, any.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          any
);

  localparam int SW = PW + 1;

  logic [N-1:0]  rot;
  logic [PW-1:0] first;
  logic [SW-1:0] sum;

  always_comb begin
    rot   = N'({req, req} >> ptr);
    first = '0;
    any   = 1'b0;
    // Descending scan so the lowest rotated index is the one left standing.
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        first = PW'(i);
        any   = 1'b1;
      end
    end
    sum = {1'b0, first} + {1'b0, ptr};
    if (sum >= SW'(N)) sum = sum - SW'(N);
    gnt_idx = sum[PW-1:0];
    gnt     = any ? (N'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx between N_REQ byte requesters.
// Optional grant locking is compiled in with `define UART_TX_SCHED_LOCK_EN.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*BYTE_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ-1:0]        req_lock,
  input  logic [1:0]              cfg_data_bit_num,
  input  logic                    cfg_stop_bit_num,
  input  logic                    cfg_parity_en,
  input  logic                    cfg_parity_type,
  input  logic                    tx_done,
  output logic                    start_tx,
  output logic [BYTE_W-1:0]       tx_data,
  output logic [1:0]              data_bit_num,
  output logic                    stop_bit_num,
  output logic                    parity_en,
  output logic                    parity_type,
  output logic [2:0]              grant_id,
  output logic                    busy,
  output logic                    err_timeout,
  output logic [1:0]              state_dbg
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SW = PW + 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t             state;
  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      gidx;
  logic [TW-1:0]      tcnt;

  logic [N_REQ-1:0]   arb_gnt;
  logic [PW-1:0]      arb_idx;
  logic               arb_any;

  logic [N_REQ-1:0]   sel_gnt;
  logic [PW-1:0]      sel_idx;
  logic               sel_any;
  logic               adv_ptr;
  logic               grant;
  logic [SW-1:0]      nsum;
  logic [PW-1:0]      next_ptr;
  logic [BYTE_W-1:0]  sel_byte;
  logic               tmo_hit;

`ifdef UART_TX_SCHED_LOCK_EN
  logic               lock_arm;
`else
  logic               unused_lock;
  assign unused_lock = ^req_lock;
`endif

  rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  // Handshake: a byte moves when req_valid[i] & req_ready[i] at a rising edge.
  // req_ready is combinational on req_valid, one-hot, and only raised in IDLE
  // with tx_done high; a requester that drops valid early is simply skipped.
  always_comb begin
    sel_gnt = arb_gnt;
    sel_idx = arb_idx;
    sel_any = arb_any;
    adv_ptr = 1'b1;
`ifdef UART_TX_SCHED_LOCK_EN
    if (lock_arm && req_lock[gidx] && req_valid[gidx]) begin
      sel_gnt = N_REQ'(1) << gidx;
      sel_idx = gidx;
      sel_any = 1'b1;
      adv_ptr = 1'b0;
    end
`endif
    grant     = (state == IDLE) && tx_done && sel_any;
    req_ready = grant ? sel_gnt : '0;

    nsum = {1'b0, sel_idx} + SW'(1);
    if (nsum >= SW'(N_REQ)) nsum = '0;
    next_ptr = nsum[PW-1:0];

    sel_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel_idx == PW'(i)) sel_byte = req_data[i*BYTE_W +: BYTE_W];
    end

    tmo_hit = (TIMEOUT != 0) && (tcnt == TW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      gidx         <= '0;
      tcnt         <= '0;
      start_tx     <= 1'b0;
      tx_data      <= '0;
      data_bit_num <= '0;
      stop_bit_num <= 1'b0;
      parity_en    <= 1'b0;
      parity_type  <= 1'b0;
      err_timeout  <= 1'b0;
`ifdef UART_TX_SCHED_LOCK_EN
      lock_arm     <= 1'b0;
`endif
    end else begin
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            tx_data      <= sel_byte;
            data_bit_num <= cfg_data_bit_num;
            stop_bit_num <= cfg_stop_bit_num;
            parity_en    <= cfg_parity_en;
            parity_type  <= cfg_parity_type;
            gidx         <= sel_idx;
            if (adv_ptr) rr_ptr <= next_ptr;
            start_tx     <= 1'b1;
            tcnt         <= '0;
            state        <= LAUNCH;
          end
        end
        LAUNCH: begin
          // The transmitter leaving idle beats an expiry in the same cycle.
          if (!tx_done) begin
            start_tx <= 1'b0;
            state    <= SEND;
          end else if (tmo_hit) begin
            start_tx    <= 1'b0;
            err_timeout <= 1'b1;
            state       <= IDLE;
`ifdef UART_TX_SCHED_LOCK_EN
            lock_arm    <= 1'b0;
`endif
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        SEND: begin
          if (tx_done) begin
            state <= IDLE;
`ifdef UART_TX_SCHED_LOCK_EN
            lock_arm <= 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign grant_id  = 3'(gidx);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: directed scenarios plus randomized
// transactions compared against a transaction-level scheduler model.
module tb_uart_tx_sched;
  import uart_pkg::*;

  localparam int N_REQ   = 4;
  localparam int TIMEOUT = 20;
  localparam int BUDGET  = TIMEOUT + 10;

  localparam logic [4:0] CFG_8N1 = {DBITS_8, 1'b0, 1'b0, 1'b0};
  localparam logic [4:0] CFG_7E2 = {DBITS_7, 1'b1, 1'b1, 1'b0};
  localparam logic [4:0] CFG_5O1 = {DBITS_5, 1'b0, 1'b1, 1'b1};

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid, req_ready, req_lock;
  logic [31:0] req_data;
  logic [1:0]  cfg_data_bit_num;
  logic        cfg_stop_bit_num, cfg_parity_en, cfg_parity_type;
  logic        tx_done;
  logic        start_tx;
  logic [7:0]  tx_data;
  logic [1:0]  data_bit_num;
  logic        stop_bit_num, parity_en, parity_type;
  logic [2:0]  grant_id;
  logic        busy, err_timeout;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  uart_tx_sched #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .req_lock         (req_lock),
    .cfg_data_bit_num (cfg_data_bit_num),
    .cfg_stop_bit_num (cfg_stop_bit_num),
    .cfg_parity_en    (cfg_parity_en),
    .cfg_parity_type  (cfg_parity_type),
    .tx_done          (tx_done),
    .start_tx         (start_tx),
    .tx_data          (tx_data),
    .data_bit_num     (data_bit_num),
    .stop_bit_num     (stop_bit_num),
    .parity_en        (parity_en),
    .parity_type      (parity_type),
    .grant_id         (grant_id),
    .busy             (busy),
    .err_timeout      (err_timeout),
    .state_dbg        (state_dbg)
  );

  // ---------------- scoreboard and reference model ----------------
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_data = '0;
  logic [4:0] exp_cfg  = '0;
  int         exp_gid  = 0;
  int         ptr_m    = 0;
  int         last_g_m = 0;
  bit         lock_arm_m = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_latched(input string tag);
    check({tag, "_data"}, tx_data, exp_data);
    check({tag, "_cfg"}, {data_bit_num, stop_bit_num, parity_en, parity_type}, exp_cfg);
    check({tag, "_gid"}, grant_id, exp_gid);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_start"}, start_tx, 0);
    check({tag, "_data"}, tx_data, 0);
    check({tag, "_cfg"}, {data_bit_num, stop_bit_num, parity_en, parity_type}, 0);
    check({tag, "_gid"}, grant_id, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err_timeout, 0);
    check({tag, "_ready"}, req_ready, 0);
    check({tag, "_state"}, state_dbg, IDLE);
  endtask

  task automatic model_reset;
    ptr_m = 0; last_g_m = 0; lock_arm_m = 1'b0;
    exp_data = '0; exp_cfg = '0; exp_gid = 0;
    exp_q.delete();
  endtask

  task automatic drive_cfg(input logic [4:0] cfg);
    {cfg_data_bit_num, cfg_stop_bit_num, cfg_parity_en, cfg_parity_type} = cfg;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; req_lock = '0; tx_done = 1'b1;
    #1 check_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Called at a negedge with the DUT in IDLE; ends at the negedge after the grant.
  task automatic do_grant(input logic [3:0] mask, input logic [31:0] data,
                          input logic [4:0] cfg, input logic [3:0] lock);
    int w;
    bit locked;
    w = -1;
    locked = 1'b0;
    req_valid = mask; req_data = data; req_lock = lock; tx_done = 1'b1;
    drive_cfg(cfg);
`ifdef UART_TX_SCHED_LOCK_EN
    if (lock_arm_m && lock[last_g_m] && mask[last_g_m]) begin
      w = last_g_m;
      locked = 1'b1;
    end
`endif
    for (int k = 0; k < N_REQ; k++) begin
      if (w < 0 && mask[(ptr_m + k) % N_REQ]) w = (ptr_m + k) % N_REQ;
    end
    if (w < 0) w = 0;
    if (!locked) ptr_m = (w + 1) % N_REQ;
    last_g_m = w;
    exp_q.push_back(data[w*8 +: 8]);
    exp_cfg = cfg;
    exp_gid = w;
    #1;
    check("ready_grant", req_ready, 4'(1) << w);
    check("busy_idle", busy, 0);
    @(posedge clk);
    @(negedge clk);
    exp_data = exp_q.pop_front();
    check("start_rise", start_tx, 1);
    check("busy_launch", busy, 1);
    check("ready_launch", req_ready, 0);
    check("err_clear", err_timeout, 0);
    check_latched("grant");
    req_valid = mask & ~(4'(1) << w);
    req_data  = $urandom;
    drive_cfg(5'($urandom));
  endtask

  // tx_done stays high for d LAUNCH cycles, then drops.
  task automatic do_launch(input int d, output bit aborted);
    int hi, c, exp_hi;
    bit done, exp_err;
    hi = 1; c = 1; done = 1'b0;
    while (!done) begin
      tx_done = (c <= d);
      @(posedge clk);
      @(negedge clk);
      if (start_tx) begin
        hi++;
        check("ready_in_launch", req_ready, 0);
        check_latched("launch");
      end else begin
        done = 1'b1;
      end
      c++;
      if (!done && c > BUDGET) begin
        check("launch_budget", start_tx, 0);
        done = 1'b1;
      end
    end
    exp_err = (d >= TIMEOUT);
    exp_hi  = exp_err ? TIMEOUT : d + 1;
    check("start_cycles", hi, exp_hi);
    check("err_timeout", err_timeout, exp_err);
    check("busy_after_launch", busy, !exp_err);
    if (exp_err) lock_arm_m = 1'b0;
    aborted = exp_err;
  endtask

  // In SEND for f cycles with disturbing inputs, then tx_done rises.
  task automatic do_send(input int f, input logic [4:0] cfg_new);
    for (int i = 0; i < f; i++) begin
      req_valid = 4'($urandom);
      drive_cfg(cfg_new);
      tx_done = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("ready_in_send", req_ready, 0);
      check("busy_send", busy, 1);
      check("start_send", start_tx, 0);
      check("err_send", err_timeout, 0);
      check_latched("send");
    end
    tx_done = 1'b1;
    req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    check("busy_done", busy, 0);
    lock_arm_m = 1'b1;
  endtask

  task automatic run_txn(input logic [3:0] mask, input logic [31:0] data, input logic [4:0] cfg,
                         input logic [3:0] lock, input int d, input int f);
    bit ab;
    do_grant(mask, data, cfg, lock);
    do_launch(d, ab);
    if (!ab) do_send(f, 5'($urandom));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ab;
    int g;
    rst_n = 1'b0; req_valid = '0; req_data = '0; req_lock = '0; tx_done = 1'b1;
    drive_cfg('0);
    do_reset();

    // Single request from requester 2.
    run_txn(4'b0100, 32'h00A5_0000, CFG_8N1, 4'b0000, 3, 3);
    check("single_gid", grant_id, 2);

    // All requesters pending: grants rotate from 0.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      do_grant(4'b1111, $urandom, 5'($urandom), 4'b0000);
      check("rr_order", grant_id, k % N_REQ);
      do_launch(2, ab);
      if (!ab) do_send(2, 5'($urandom));
    end

    // Timeout abort, then the next requester wins; then the boundary just short of it.
    run_txn(4'b1111, $urandom, CFG_8N1, 4'b0000, TIMEOUT + 5, 1);
    g = grant_id;
    run_txn(4'b1111, $urandom, CFG_8N1, 4'b0000, TIMEOUT - 1, 2);
    check("after_timeout_gid", grant_id, (g + 1) % N_REQ);
    run_txn(4'b1111, $urandom, CFG_8N1, 4'b0000, TIMEOUT, 1);

    // Config changes during SEND do not reach the latched outputs.
    do_grant(4'b0001, $urandom, CFG_7E2, 4'b0000);
    do_launch(1, ab);
    do_send(4, CFG_5O1);
    check("cfg_hold_dbits", data_bit_num, DBITS_7);
    check("cfg_hold_ptype", parity_type, 0);

    // Reset in the middle of SEND, then no grant while tx_done is low.
    do_grant(4'b1000, $urandom, CFG_7E2, 4'b0000);
    do_launch(2, ab);
    tx_done = 1'b0;
    @(posedge clk);
    #2;
    req_valid = 4'b1111;
    rst_n = 1'b0;
    #1 check_reset_vals("mid_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("post_rst_ready", req_ready, 0);
      check("post_rst_busy", busy, 0);
      check("post_rst_start", start_tx, 0);
    end
    run_txn(4'b1111, $urandom, CFG_5O1, 4'b0000, 2, 2);
    check("post_rst_gid", grant_id, 0);

`ifdef UART_TX_SCHED_LOCK_EN
    // Lock held on requester 1 keeps the grant there; dropping it lets 3 in.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      run_txn(4'b1010, $urandom, CFG_8N1, 4'b0010, 2, 2);
      check("lock_gid", grant_id, 1);
    end
    run_txn(4'b1010, $urandom, CFG_8N1, 4'b0000, 2, 2);
    check("unlock_gid", grant_id, 3);
`endif

    // Randomized traffic against the model.
    for (int k = 0; k < 40; k++) begin
      run_txn(4'($urandom_range(1, 15)), $urandom, 5'($urandom), 4'($urandom),
              $urandom_range(0, TIMEOUT + 4), $urandom_range(1, 4));
    end

    req_valid = '0;
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
